// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// default bus widths and wait-counter sizing.
package data_mem_responder_pkg;

  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int WAIT_CNT_WIDTH   = 4;
  localparam int MAX_WAIT_STATES  = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/data_mem_responder_sp_ram.sv
// Synchronous single-port RAM with one write enable and a registered read
// port whose output register holds its value until the next read.
module sp_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdData;

  // Storage array is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wrData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdData <= '0;
    end else if (i_re) begin
      r_rdData <= r_mem[i_addr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the control unit RD/WR strobes: captures one
// request, inserts WAIT_STATES wait cycles, then pulses ready (or err).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RD,
  input  logic                  WR,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int                        RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]       LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [WAIT_CNT_WIDTH-1:0] LP_WAIT  = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_t                    r_state;
  logic [WAIT_CNT_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_isWrite;
  logic                      r_ready;
  logic                      r_err;
  logic                      r_busy;

  logic                      w_req;
  logic                      w_bad;
  logic                      w_waitDone;
  logic                      w_ramWe;
  logic                      w_ramRe;

  assign w_req      = RD ^ WR;
  assign w_bad      = (RD & WR) | ((RD | WR) & ({1'b0, addr} >= LP_DEPTH));
  assign w_waitDone = (r_state == S_WAIT) && (r_count == '0);

  // Reads load the RAM output register on the edge into ACK so data is valid
  // alongside ready; writes commit on the edge leaving ACK, so a reset seen
  // during ACK can still cancel them.
  assign w_ramRe = w_waitDone && !r_isWrite && !rst;
  assign w_ramWe = (r_state == S_ACK) && r_isWrite && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_isWrite <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_bad) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else if (w_req) begin
            r_state   <= S_WAIT;
            r_count   <= LP_WAIT;
            r_addr    <= addr;
            r_data    <= data_in;
            r_isWrite <= WR;
            r_busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_count == '0) begin
            r_state <= S_ACK;
            r_ready <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
        end
        // Wait for both strobes to drop so a held strobe is not re-executed.
        S_DONE: begin
          if (!RD && !WR) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  sp_ram #(
    .ADDR_WIDTH(RAM_AW),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_ramWe),
    .i_re    (w_ramRe),
    .i_addr  (r_addr[RAM_AW-1:0]),
    .i_wrData(r_data),
    .o_rdData(data_out)
  );

  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_STATES=2/DEPTH=512 instance driven from
// a per-cycle vector table, and a WAIT_STATES=0 instance for the held-strobe case.
module tb_data_mem_responder;

  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstA, rdA, wrA, rdyA, errA, busyA;
  logic [AW-1:0] addrA;
  logic [DW-1:0] dinA, doutA;
  logic          rstB, rdB, wrB, rdyB, errB, busyB;
  logic [AW-1:0] addrB;
  logic [DW-1:0] dinB, doutB;

  data_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(512), .WAIT_STATES(2)
  ) dutA (
    .clk(clk), .rst(rstA), .RD(rdA), .WR(wrA), .addr(addrA), .data_in(dinA),
    .data_out(doutA), .ready(rdyA), .err(errA), .busy(busyA)
  );

  data_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(1024), .WAIT_STATES(0)
  ) dutB (
    .clk(clk), .rst(rstB), .RD(rdB), .WR(wrB), .addr(addrB), .data_in(dinB),
    .data_out(doutB), .ready(rdyB), .err(errB), .busy(busyB)
  );

  // One record per cycle: inputs for that cycle and the registered outputs
  // expected during it (flags are {ready, err, busy}).
  typedef struct {
    logic          rst;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [2:0]    eFlags;
    logic          chk;
    logic [DW-1:0] eDout;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic addVec(input logic r, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [2:0] f, input logic c, input logic [DW-1:0] e);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.din = d;
    v.eFlags = f; v.chk = c; v.eDout = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on instance A and compare its outputs for that cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rstA = v.rst; rdA = v.rd; wrA = v.wr; addrA = v.addr; dinA = v.din;
    #1;
    checkOutput($sformatf("A cyc%0d flags", idx), 32'({rdyA, errA, busyA}), 32'(v.eFlags));
    if (v.chk) checkOutput($sformatf("A cyc%0d data_out", idx), 32'(doutA), 32'(v.eDout));
  endtask

  task automatic stepB(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rstB = 1'b0; rdB = rd; wrB = wr; addrB = a; dinB = d;
    #1;
  endtask

  initial begin
    int pulses;
    int firstAt;

    rstA = 1'b1; rdA = 1'b0; wrA = 1'b0; addrA = '0; dinA = '0;
    rstB = 1'b1; rdB = 1'b0; wrB = 1'b0; addrB = '0; dinB = '0;
    repeat (2) @(negedge clk);

    // Write 0x005=BEEF (ready at cycle 4), data_in change in WAIT ignored
    addVec(0,0,1,10'h005,16'hBEEF,3'b000,1,16'h0000);
    addVec(0,0,1,10'h005,16'hBEEF,3'b001,0,16'h0000);
    addVec(0,0,1,10'h005,16'hFFFF,3'b001,0,16'h0000);
    addVec(0,0,1,10'h005,16'hBEEF,3'b001,0,16'h0000);
    addVec(0,0,1,10'h005,16'hBEEF,3'b101,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Read it back
    addVec(0,1,0,10'h005,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h005,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h005,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h005,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h005,16'h0000,3'b101,1,16'hBEEF);
    addVec(0,0,0,10'h000,16'h0000,3'b000,1,16'hBEEF);
    // RD and WR together: err pulse only, RAM untouched
    addVec(0,1,1,10'h005,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,1,10'h005,16'h0000,3'b010,0,16'h0000);
    addVec(0,1,1,10'h005,16'h0000,3'b000,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Read 0x005 with strobe dropped early and addr wiggled in WAIT
    addVec(0,1,0,10'h005,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h005,16'h0000,3'b001,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,0,0,10'h1FF,16'h0000,3'b001,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b101,1,16'hBEEF);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Back-to-back write 0x000=0A0A, one idle cycle, read 0x000
    addVec(0,0,1,10'h000,16'h0A0A,3'b000,0,16'h0000);
    addVec(0,0,1,10'h000,16'h0A0A,3'b001,0,16'h0000);
    addVec(0,0,1,10'h000,16'h0A0A,3'b001,0,16'h0000);
    addVec(0,0,1,10'h000,16'h0A0A,3'b001,0,16'h0000);
    addVec(0,0,1,10'h000,16'h0A0A,3'b101,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b101,1,16'h0A0A);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Address 0x200 is past DEPTH=512; next read of 0x000 unaffected
    addVec(0,1,0,10'h200,16'h0000,3'b000,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b010,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h000,16'h0000,3'b101,1,16'h0A0A);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Seed 0x010=5555
    addVec(0,0,1,10'h010,16'h5555,3'b000,0,16'h0000);
    addVec(0,0,1,10'h010,16'h5555,3'b001,0,16'h0000);
    addVec(0,0,1,10'h010,16'h5555,3'b001,0,16'h0000);
    addVec(0,0,1,10'h010,16'h5555,3'b001,0,16'h0000);
    addVec(0,0,1,10'h010,16'h5555,3'b101,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Write 0x010=1234 aborted by reset in WAIT
    addVec(0,0,1,10'h010,16'h1234,3'b000,0,16'h0000);
    addVec(0,0,1,10'h010,16'h1234,3'b001,0,16'h0000);
    addVec(1,0,1,10'h010,16'h1234,3'b001,1,16'h0A0A);
    addVec(0,0,0,10'h000,16'h0000,3'b000,1,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b101,1,16'h5555);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);
    // Write 0x010=7777 cancelled by reset during ACK
    addVec(0,0,1,10'h010,16'h7777,3'b000,0,16'h0000);
    addVec(0,0,1,10'h010,16'h7777,3'b001,0,16'h0000);
    addVec(0,0,1,10'h010,16'h7777,3'b001,0,16'h0000);
    addVec(0,0,1,10'h010,16'h7777,3'b001,0,16'h0000);
    addVec(1,0,1,10'h010,16'h7777,3'b101,0,16'h0000);
    addVec(0,0,0,10'h000,16'h0000,3'b000,1,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b000,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b001,0,16'h0000);
    addVec(0,1,0,10'h010,16'h0000,3'b101,1,16'h5555);
    addVec(0,0,0,10'h000,16'h0000,3'b000,0,16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // WAIT_STATES=0: write 0x3FF (top of range), ready two cycles after capture
    stepB(1'b0, 1'b1, 10'h3FF, 16'hC0DE);
    checkOutput("B reset flags", 32'({rdyB, errB, busyB}), 32'(3'b000));
    checkOutput("B reset data_out", 32'(doutB), 32'h0);
    stepB(1'b0, 1'b1, 10'h3FF, 16'hC0DE);
    checkOutput("B write wait", 32'({rdyB, errB, busyB}), 32'(3'b001));
    stepB(1'b0, 1'b1, 10'h3FF, 16'hC0DE);
    checkOutput("B write ack", 32'({rdyB, errB, busyB}), 32'(3'b101));
    stepB(1'b0, 1'b0, 10'h000, 16'h0000);
    checkOutput("B write done", 32'({rdyB, errB, busyB}), 32'(3'b000));

    // RD held five cycles must yield exactly one ready, at cycle 2
    pulses  = 0;
    firstAt = -1;
    for (int c = 0; c < 8; c++) begin
      stepB(c < 5, 1'b0, 10'h3FF, 16'h0000);
      if (rdyB === 1'b1) begin
        pulses++;
        if (firstAt < 0) firstAt = c;
        checkOutput($sformatf("B held read data c%0d", c), 32'(doutB), 32'hC0DE);
      end
      checkOutput($sformatf("B held busy c%0d", c), 32'(busyB), 32'(c == 1 || c == 2));
      checkOutput($sformatf("B held err c%0d", c), 32'(errB), 32'h0);
    end
    checkOutput("B ready pulse count", 32'(pulses), 32'd1);
    checkOutput("B ready pulse cycle", 32'(firstAt), 32'd2);
    checkOutput("B data_out holds", 32'(doutB), 32'hC0DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
